// File: rtl/freq_tune_pkg.sv
// Shared types, direction codes and the saturating clamp used by the LO tuning controller.
package freq_tune_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

    // Clamp v to the range of a w-bit signed word.
    function automatic longint sat_clamp(input longint v, input int unsigned w);
        longint hi;
        longint lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/freq_tune_ctrl_if.sv
// Sample-direction input and tuning-word output bundle of freq_tune_ctrl.
interface freq_tune_ctrl_if #(
    parameter int WORD_W = 16
);
    logic                     en;
    logic                     dir_valid;
    logic [1:0]               freq_mod;
    logic signed [WORD_W-1:0] tune_word;
    logic                     step_pulse;
    logic                     locked;
    logic                     sat;
    logic [1:0]               state_o;

    modport master (
        output en, dir_valid, freq_mod,
        input  tune_word, step_pulse, locked, sat, state_o
    );

    modport slave (
        input  en, dir_valid, freq_mod,
        output tune_word, step_pulse, locked, sat, state_o
    );
endinterface

// File: rtl/freq_tune_ctrl_dir_vote_window.sv
// Counts up/down votes over WIN enabled samples and presents the registered net vote
// with a one-cycle win_done strobe; everything holds while en is low.
module dir_vote_window
    import freq_tune_pkg::*;
#(
    parameter int WIN = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         dir_valid,
    input  logic [1:0]                   freq_mod,
    output logic                         win_done,
    output logic signed [$clog2(WIN)+1:0] net
);
    localparam int CW = $clog2(WIN);

    logic [CW-1:0] samp_cnt;
    logic [CW:0]   up_cnt;
    logic [CW:0]   dn_cnt;
    logic [CW:0]   up_next;
    logic [CW:0]   dn_next;
    logic          counted;
    logic          last_samp;

    assign counted   = en & dir_valid;
    assign up_next   = up_cnt + (CW+1)'(counted && freq_mod == DIR_UP);
    assign dn_next   = dn_cnt + (CW+1)'(counted && freq_mod == DIR_DN);
    assign last_samp = counted && (samp_cnt == CW'(WIN - 1));

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            samp_cnt <= '0;
            up_cnt   <= '0;
            dn_cnt   <= '0;
            win_done <= 1'b0;
            net      <= '0;
        end else if (en) begin
            win_done <= last_samp;
            if (last_samp) begin
                net      <= $signed({1'b0, up_next}) - $signed({1'b0, dn_next});
                samp_cnt <= '0;
                up_cnt   <= '0;
                dn_cnt   <= '0;
            end else if (counted) begin
                samp_cnt <= samp_cnt + 1'b1;
                up_cnt   <= up_next;
                dn_cnt   <= dn_next;
            end
        end
    end

endmodule

// File: rtl/freq_tune_ctrl.sv
// LO tuning controller: turns windowed direction votes into coarse/fine steps of a
// signed tuning word, tracking acquire/track/lock state and sticky saturation.
module freq_tune_ctrl
    import freq_tune_pkg::*;
#(
    parameter int WORD_W       = 16,
    parameter int WIN          = 16,
    parameter int THRESH       = 8,
    parameter int COARSE_STEP  = 64,
    parameter int FINE_STEP    = 4,
    parameter int LOCK_WINDOWS = 4,
    parameter int INIT_WORD    = 0
) (
    input  logic            clk,
    input  logic            reset,
    freq_tune_ctrl_if.slave bus
);
    localparam int NW = $clog2(WIN) + 2;
    localparam int LW = $clog2(LOCK_WINDOWS + 1);
    localparam logic signed [NW-1:0] THR = NW'(THRESH);

    logic                     win_done;
    logic signed [NW-1:0]     net;
    logic [1:0]               dir;

    state_t                   state_q, state_d;
    logic signed [WORD_W-1:0] tune_q, tune_d, cand;
    logic                     sat_q, sat_d;
    logic                     pulse_q, pulse_d;
    logic                     pending_q, pending_d;
    logic [1:0]               last_dir_q, last_dir_d;
    logic [LW-1:0]            nostep_q, nostep_d;
    logic                     do_step, use_coarse;
    longint                   step_mag, sum, clamped;

    dir_vote_window #(.WIN(WIN)) u_vote (
        .clk      (clk),
        .reset    (reset),
        .en       (bus.en),
        .dir_valid(bus.dir_valid),
        .freq_mod (bus.freq_mod),
        .win_done (win_done),
        .net      (net)
    );

    assign dir = (net >= THR)  ? DIR_UP :
                 (net <= -THR) ? DIR_DN : DIR_NONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACQUIRE;
            tune_q     <= WORD_W'(INIT_WORD);
            sat_q      <= 1'b0;
            pulse_q    <= 1'b0;
            pending_q  <= 1'b0;
            last_dir_q <= DIR_NONE;
            nostep_q   <= '0;
        end else begin
            state_q    <= state_d;
            tune_q     <= tune_d;
            sat_q      <= sat_d;
            pulse_q    <= pulse_d;
            pending_q  <= pending_d;
            last_dir_q <= last_dir_d;
            nostep_q   <= nostep_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        tune_d     = tune_q;
        sat_d      = sat_q;
        pulse_d    = 1'b0;
        pending_d  = pending_q;
        last_dir_d = last_dir_q;
        nostep_d   = nostep_q;
        do_step    = 1'b0;
        use_coarse = 1'b0;

        if (bus.en && win_done) begin
            if (dir != DIR_NONE) last_dir_d = dir;
            case (state_q)
                ACQUIRE: begin
                    if (dir != DIR_NONE) begin
                        do_step = 1'b1;
                        if (last_dir_q == DIR_NONE || dir == last_dir_q) begin
                            use_coarse = 1'b1;
                        end else begin
                            state_d = TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (dir != DIR_NONE) begin
                        do_step  = 1'b1;
                        nostep_d = '0;
                    end else if (nostep_q == LW'(LOCK_WINDOWS - 1)) begin
                        state_d  = LOCKED;
                        nostep_d = '0;
                    end else begin
                        nostep_d = nostep_q + 1'b1;
                    end
                end
                LOCKED: begin
                    // A single off-centre window is tolerated; two in a row break lock.
                    if (dir == DIR_NONE) begin
                        pending_d = 1'b0;
                    end else if (pending_q) begin
                        do_step   = 1'b1;
                        pending_d = 1'b0;
                        state_d   = TRACK;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
                default: state_d = ACQUIRE;
            endcase
        end

        step_mag = use_coarse ? longint'(COARSE_STEP) : longint'(FINE_STEP);
        sum      = longint'(tune_q) + ((dir == DIR_UP) ? step_mag : -step_mag);
        clamped  = sat_clamp(sum, WORD_W);
        cand     = WORD_W'(clamped);
        if (do_step) begin
            tune_d  = cand;
            sat_d   = sat_q | (clamped != sum);
            pulse_d = (cand != tune_q);
        end
    end

    assign bus.tune_word  = tune_q;
    assign bus.step_pulse = pulse_q;
    assign bus.locked     = (state_q == LOCKED);
    assign bus.sat        = sat_q;
    assign bus.state_o    = state_q;

endmodule

// File: doc/freq_tune_ctrl.md
Name: freq_tune_ctrl

Overview:
- Downstream stage of freq_correction: consumes its 2-bit freq_mod direction indication, one per IQ sample.
- Majority-votes directions over fixed windows and steps a signed LO tuning word up or down.
- Uses coarse steps while acquiring, fine steps while tracking, and declares lock when no correction is needed for several windows.
- tune_word feeds the NCO/LO programming logic.

Parameters:
WORD_W, 16, tune_word width (signed two's complement)
WIN, 16, valid samples per vote window (power of 2, 4..256)
THRESH, 8, |up-dn| needed to step (1..WIN)
COARSE_STEP, 64, step size in ACQUIRE
FINE_STEP, 4, step size in TRACK/LOCKED
LOCK_WINDOWS, 4, consecutive no-step windows to declare lock
INIT_WORD, 0, tune_word after reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  enable; when low, samples are ignored and all state is held
dir_valid  in  1  freq_mod is valid this cycle (one pulse per IQ sample)
freq_mod  in  2  direction: 01 raise, 10 lower, 00/11 no vote (counted as a sample, no vote)
tune_word  out  WORD_W  signed tuning word
step_pulse  out  1  one-cycle pulse when tune_word changes
locked  out  1  high in LOCKED
sat  out  1  sticky; set when a step clamps at the signed min/max; cleared only by reset
state_o  out  2  current state (debug)

Behaviour:
- Reset (synchronous, active-high; valid at any time, including mid-window) forces the next-edge values:
  - tune_word=INIT_WORD; step_pulse=0; locked=0; sat=0; state=ACQUIRE.
  - Vote counters, sample counter, no-step counter and last_dir are all cleared.
- Sampling:
  - A sample counts only when en=1 and dir_valid=1.
  - Each counted sample increments samp_cnt; 01 increments up_cnt, 10 increments dn_cnt.
- Window close:
  - A window closes on the counted sample that makes samp_cnt reach WIN.
  - Net = up_cnt - dn_cnt includes that sample's vote.
  - On the next edge, counters clear and the decision registers.
  - Latency: tune_word and step_pulse update on the clock edge one cycle after the WIN-th sample cycle.
- Decision: dir=+1 if net>=THRESH; dir=-1 if net<=-THRESH; otherwise dir=0.
- State machine:
  - ACQUIRE:
    - dir equals last_dir or last_dir=0 -> step by COARSE_STEP.
    - dir opposite to last_dir -> step by FINE_STEP and go to TRACK.
    - dir=0 -> no step, remain.
  - TRACK:
    - dir!=0 -> step by FINE_STEP and clear nostep_cnt.
    - dir=0 -> increment nostep_cnt; on reaching LOCK_WINDOWS go to LOCKED with locked=1.
  - LOCKED:
    - dir!=0 in one window -> no step; set pending.
    - A second consecutive dir!=0 window -> step by FINE_STEP, go to TRACK, locked=0.
    - A dir=0 window clears pending.
- last_dir updates to dir whenever dir!=0.
- Arithmetic:
  - Compute in WORD_W+1 bits, then clamp to [-2^(WORD_W-1), 2^(WORD_W-1)-1].
  - A clamp sets sat.
  - step_pulse fires only if tune_word actually changed (a clamp with no change gives no pulse).
- en low mid-window: partial counts are held and the window resumes when en returns. en has no effect on reset.
- dir_valid asserted on consecutive cycles is legal; every such cycle is counted.

Decomposition:
- Package freq_tune_pkg holds:
  - state enum (ACQUIRE=0, TRACK=1, LOCKED=2);
  - direction constants DIR_UP=2'b01, DIR_DN=2'b10;
  - signed saturate function.
- Sub-module dir_vote_window: sample/up/dn counters.
  - Outputs: win_done (1 cycle), net (signed, $clog2(WIN)+2 bits).
  - Inputs: clk, reset, en, dir_valid, freq_mod.
- The top module holds the FSM, step/saturation logic and outputs.

Test Plan:
1. Reset; 16 counted samples of 01 (dir_valid every 3rd cycle) -> one cycle after the 16th, tune_word=64, step_pulse high exactly 1 cycle, state_o=ACQUIRE.
2. Continue with 16 samples of 10 -> tune_word=60, state_o=TRACK; 16 more samples of 10 -> tune_word=56.
3. Four windows of 8x01 + 8x10 each (net 0) -> locked=1 after the 4th window, tune_word stays 56, no step_pulse; one window of 16x01 -> no step; a second -> tune_word=60, locked=0, TRACK.
4. INIT_WORD=32760; 16 samples of 01 -> tune_word=32767, sat=1, step_pulse=1; next up window -> no pulse, sat stays 1.
5. After 10 samples of 01, drop en for 20 cycles with dir_valid toggling -> no window close; 6 more enabled samples close the window, tune_word=64.
6. After 10 samples of 10, assert reset 1 cycle -> tune_word=0, locked=0, sat=0; the next 16 samples of 01 give tune_word=64 (old votes discarded).
